// File: rtl/kara_div_pkg.sv
// ---------------------------------------------------------------------------
// kara_div_pkg
// Shared definitions for the kara_div restoring divider.
//   KARA_W  : default operand width, kept equal to the kara_top multiplier's
//   state_t : divider FSM encoding (IDLE/RUN/DONE/ZERO)
// ---------------------------------------------------------------------------
package kara_div_pkg;

    localparam int KARA_W = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ZERO = 2'd3
    } state_t;

endpackage : kara_div_pkg

// File: rtl/kara_div_if.sv
// ---------------------------------------------------------------------------
// kara_div_if
// Launch/result bundle between a requester (master) and kara_div (slave).
//   start : launch request, rising-edge sensed by the divider
//   z     : 2W-bit dividend,  y : W-bit divisor (sampled on launch)
//   q     : 2W-bit quotient,  r : W-bit remainder
//   busy  : operation in flight, done : one-cycle result strobe
//   dbz   : divide-by-zero flag, valid with done
// ---------------------------------------------------------------------------
interface kara_div_if
    import kara_div_pkg::*;
#(
    parameter int W = KARA_W
) ();

    logic             start;
    logic [2*W-1:0]   z;
    logic [W-1:0]     y;
    logic [2*W-1:0]   q;
    logic [W-1:0]     r;
    logic             busy;
    logic             done;
    logic             dbz;

    modport master (
        output start, z, y,
        input  q, r, busy, done, dbz
    );

    modport slave (
        input  start, z, y,
        output q, r, busy, done, dbz
    );

endinterface : kara_div_if

// File: rtl/kara_div_step.sv
// ---------------------------------------------------------------------------
// kara_div_step
// One combinational restoring-division iteration.
//   i_acc_hi : current partial remainder (W+1 bits)
//   i_bit    : next dividend bit shifted in at the LSB
//   i_div    : divisor (W bits)
//   o_acc_hi : partial remainder after the trial subtraction
//   o_qbit   : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module kara_div_step
    import kara_div_pkg::*;
#(
    parameter int W = KARA_W
) (
    input  logic [W:0]    i_acc_hi,
    input  logic          i_bit,
    input  logic [W-1:0]  i_div,
    output logic [W:0]    o_acc_hi,
    output logic          o_qbit
);

    logic [W+1:0] w_shift;
    logic [W+1:0] w_trial;

    // Shift in the next dividend bit and attempt to subtract the divisor.
    // The partial remainder is always below the divisor, so the shifted
    // value fits in W+1 bits and the W+2-bit difference has a clean sign
    // bit: MSB set means the subtraction went negative and is discarded.
    always_comb begin
        w_shift  = {i_acc_hi, i_bit};
        w_trial  = w_shift - {2'b00, i_div};
        o_qbit   = ~w_trial[W+1];
        o_acc_hi = o_qbit ? w_trial[W:0] : w_shift[W:0];
    end

endmodule : kara_div_step

// File: rtl/kara_div.sv
// ---------------------------------------------------------------------------
// kara_div
// Radix-2 restoring divider, one quotient bit per clock: q = z / y, r = z % y
// with a 2W-bit dividend and W-bit divisor. A zero divisor short-circuits to
// q = all ones, r = z[W-1:0], dbz = 1.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : kara_div_if slave (start/z/y in, q/r/busy/done/dbz out)
// Launch to done takes 2W+1 clocks (2 clocks for divide-by-zero).
// ---------------------------------------------------------------------------
module kara_div
    import kara_div_pkg::*;
#(
    parameter int W = KARA_W
) (
    input  logic        clk,
    input  logic        rst_n,
    kara_div_if.slave   bus
);

    localparam int CW = $clog2(2*W) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_d;
    logic [W:0]         r_acc_hi;
    logic [2*W-1:0]     r_acc_lo;
    logic [W-1:0]       r_div;
    logic [CW-1:0]      r_cnt;
    logic [2*W-1:0]     r_q;
    logic [W-1:0]       r_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_launch;
    logic               w_run_last;
    logic               w_zero;
    logic               w_y_zero;
    logic [W:0]         w_step_hi;
    logic               w_qbit;

    kara_div_step #(.W(W)) u_step (
        .i_acc_hi (r_acc_hi),
        .i_bit    (r_acc_lo[2*W-1]),
        .i_div    (r_div),
        .o_acc_hi (w_step_hi),
        .o_qbit   (w_qbit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        w_y_zero    = (bus.y == {W{1'b0}});
        case (r_state)
            ST_IDLE: w_state_nxt = w_launch ? (w_y_zero ? ST_ZERO : ST_RUN) : ST_IDLE;
            ST_RUN:  w_state_nxt = w_run_last ? ST_DONE : ST_RUN;
            ST_ZERO: w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: launch qualification and result-write strobes.
    // A launch needs a fresh rising edge of start seen while idle, so a
    // start held across a whole operation cannot relaunch.
    always_comb begin
        w_launch   = 1'b0;
        w_run_last = 1'b0;
        w_zero     = 1'b0;
        case (r_state)
            ST_IDLE: w_launch   = bus.start & ~r_start_d;
            ST_RUN:  w_run_last = (r_cnt == CW'(1));
            ST_ZERO: w_zero     = 1'b1;
            ST_DONE: w_launch   = 1'b0;
            default: w_launch   = 1'b0;
        endcase
    end

    // Previous-cycle start for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start_d <= 1'b0;
        end else begin
            r_start_d <= bus.start;
        end
    end

    // Datapath: load operands on launch, iterate one bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_hi <= {(W+1){1'b0}};
            r_acc_lo <= {(2*W){1'b0}};
            r_div    <= {W{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else if (w_launch) begin
            r_acc_hi <= {(W+1){1'b0}};
            r_acc_lo <= bus.z;
            r_div    <= bus.y;
            r_cnt    <= CW'(2*W);
        end else if (r_state == ST_RUN) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= {r_acc_lo[2*W-2:0], w_qbit};
            r_cnt    <= r_cnt - CW'(1);
        end else begin
            r_acc_hi <= r_acc_hi;
            r_acc_lo <= r_acc_lo;
            r_div    <= r_div;
            r_cnt    <= r_cnt;
        end
    end

    // Result registers. The last RUN iteration writes straight into q/r so
    // that done coincides with the DONE state; q/r keep their previous
    // values across a launch and only change when a new result lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= {(2*W){1'b0}};
            r_r   <= {W{1'b0}};
            r_dbz <= 1'b0;
        end else if (w_launch) begin
            r_dbz <= 1'b0;
        end else if (w_run_last) begin
            r_q   <= {r_acc_lo[2*W-2:0], w_qbit};
            r_r   <= w_step_hi[W-1:0];
            r_dbz <= 1'b0;
        end else if (w_zero) begin
            // Operands are still in the accumulator, so z[W-1:0] is the low slice.
            r_q   <= {(2*W){1'b1}};
            r_r   <= r_acc_lo[W-1:0];
            r_dbz <= 1'b1;
        end else begin
            r_q   <= r_q;
            r_r   <= r_r;
            r_dbz <= r_dbz;
        end
    end

    // Handshake flags: done is high for the DONE cycle, busy spans launch to done falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_run_last | w_zero;
            if (w_launch) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dbz  = r_dbz;

endmodule : kara_div

// File: tb/tb_kara_div.sv
// ---------------------------------------------------------------------------
// tb_kara_div
// Self-checking bench for kara_div at a reduced width (W=16) so that full
// 2W+1-cycle operations stay short. Directed table vectors, multi-cycle
// corner sequences and a random sweep against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_kara_div;

    localparam int W = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    kara_div_if #(.W(W)) bus ();

    kara_div #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] z;
        logic [W-1:0]   y;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division; zero divisor gives all-ones/z-low/dbz.
    task automatic model(input logic [2*W-1:0] z, input logic [W-1:0] y,
                         output logic [2*W-1:0] q, output logic [W-1:0] r,
                         output logic dbz);
        longint unsigned zz, yy;
        zz = 64'(z);
        yy = 64'(y);
        if (yy == 0) begin
            q   = {(2*W){1'b1}};
            r   = z[W-1:0];
            dbz = 1'b1;
        end else begin
            q   = (2*W)'(zz / yy);
            r   = W'(zz % yy);
            dbz = 1'b0;
        end
    endtask

    // One full operation: launch, scramble inputs, wait for done, check all.
    task automatic run_op(input string nm, input logic [2*W-1:0] z, input logic [W-1:0] y,
                          input logic [2*W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        int n;
        int lat;
        lat = (y == 0) ? 2 : 2*W + 1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.z     = z;
        bus.y     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.z     = (2*W)'($urandom);
        bus.y     = W'($urandom);
        chk({nm, "_busy_on"}, 64'(bus.busy), 64'd1);
        n = 1;
        while (bus.done !== 1'b1 && n < 4*W + 8) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        chk({nm, "_q"}, 64'(bus.q), 64'(eq));
        chk({nm, "_r"}, 64'(bus.r), 64'(er));
        chk({nm, "_dbz"}, 64'(bus.dbz), 64'(edbz));
        if (y != 0) begin
            chk({nm, "_identity"}, 64'(bus.q) * 64'(y) + 64'(bus.r), 64'(z));
        end
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
        chk({nm, "_busy_off"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0] rz, mq;
        logic [W-1:0]   ry, mr;
        logic           mdbz;
        int             cnt;
        int             n;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{z: 32'd100,        y: 16'd7,      q: 32'd14,         r: 16'd2,      dbz: 1'b0};
        vecs[1] = '{z: 32'hFFFE0001,   y: 16'hFFFF,   q: 32'h0000FFFF,   r: 16'd0,      dbz: 1'b0};
        vecs[2] = '{z: 32'h80000000,   y: 16'd1,      q: 32'h80000000,   r: 16'd0,      dbz: 1'b0};
        vecs[3] = '{z: 32'd5,          y: 16'd9,      q: 32'd0,          r: 16'd5,      dbz: 1'b0};
        vecs[4] = '{z: 32'h1234,       y: 16'd0,      q: 32'hFFFFFFFF,   r: 16'h1234,   dbz: 1'b1};
        vecs[5] = '{z: 32'hFFFFFFFF,   y: 16'hFFFF,   q: 32'h00010001,   r: 16'd0,      dbz: 1'b0};
        vecs[6] = '{z: 32'd0,          y: 16'd3,      q: 32'd0,          r: 16'd0,      dbz: 1'b0};
        vecs[7] = '{z: 32'd1000,       y: 16'd13,     q: 32'd76,         r: 16'd12,     dbz: 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.z     = '0;
        bus.y     = '0;
        repeat (3) @(negedge clk);
        chk("rst_q", 64'(bus.q), 64'd0);
        chk("rst_r", 64'(bus.r), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz", 64'(bus.dbz), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].z, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].dbz);
        end

        // q/r/dbz hold across a launch until the new result is written.
        @(negedge clk);
        bus.start = 1'b1;
        bus.z     = 32'd77;
        bus.y     = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_q_on_launch", 64'(bus.q), 64'd76);
        chk("hold_r_on_launch", 64'(bus.r), 64'd12);
        repeat (2*W + 4) @(negedge clk);
        chk("hold_next_q", 64'(bus.q), 64'd15);

        // start held high for 2000 cycles -> exactly one done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.z     = 32'd100;
        bus.y     = 16'd7;
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        chk("held_start_done_count", 64'(cnt), 64'd1);
        chk("held_start_q", 64'(bus.q), 64'd14);

        // Extra start edges while busy are ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.z     = 32'd1000;
        bus.y     = 16'd13;
        cnt = 0;
        for (int i = 1; i < 2*W + 12; i++) begin
            @(negedge clk);
            bus.start = (i < 2*W - 4) ? i[0] : 1'b0;
            bus.z     = (2*W)'($urandom);
            bus.y     = W'($urandom);
            if (bus.done === 1'b1) cnt++;
        end
        chk("busy_edges_done_count", 64'(cnt), 64'd1);
        chk("busy_edges_q", 64'(bus.q), 64'd76);
        chk("busy_edges_r", 64'(bus.r), 64'd12);

        // Reset mid-operation: outputs clear immediately, no done afterwards.
        @(negedge clk);
        bus.start = 1'b1;
        bus.z     = 32'hABCDEF01;
        bus.y     = 16'h1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_q", 64'(bus.q), 64'd0);
        chk("midrst_r", 64'(bus.r), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        chk("midrst_dbz", 64'(bus.dbz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2*W + 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) cnt++;
        end
        chk("midrst_no_done", 64'(cnt), 64'd0);
        run_op("after_rst", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0);

        // start already high when reset releases counts as a launch.
        @(negedge clk);
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.z     = 32'd100;
        bus.y     = 16'd7;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.done !== 1'b1 && n < 4*W + 8) begin
            @(negedge clk);
            n++;
        end
        chk("rst_start_latency", 64'(n), 64'(2*W + 1));
        chk("rst_start_q", 64'(bus.q), 64'd14);
        chk("rst_start_r", 64'(bus.r), 64'd2);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       ry = '0;
                1:       ry = W'($urandom_range(1, 15));
                2:       ry = {W{1'b1}};
                default: ry = W'($urandom);
            endcase
            rz = ($urandom_range(0, 7) == 0) ? (2*W)'($urandom_range(0, 255)) : (2*W)'($urandom);
            model(rz, ry, mq, mr, mdbz);
            run_op($sformatf("rnd%0d", i), rz, ry, mq, mr, mdbz);
            if (ry != 0) begin
                chk($sformatf("rnd%0d_r_lt_y", i), 64'(bus.r < ry), 64'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_kara_div
